// File: rtl/seven_segment_decoder.sv
// Seven-segment receive monitor: debounces seg_in, decodes the digit,
// resolves 0/8 from context, checks count order, measures digit period.
// Ports: clk, reset (sync, active-low), seg_in[6:0] (bit6=top .. bit0=middle),
//   digit, digit_valid, blank, invalid, seq_error, stall, period.
module seven_segment_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 25,
  parameter int TIMEOUT       = 20_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         seg_in,
  output logic [3:0]         digit,
  output logic               digit_valid,
  output logic               blank,
  output logic               invalid,
  output logic               seq_error,
  output logic               stall,
  output logic [COUNT_W-1:0] period
);

  localparam logic [3:0] STAB = 4'(STABLE_CYCLES);
  localparam logic [COUNT_W-1:0] TO = COUNT_W'(TIMEOUT);
  localparam logic [COUNT_W-1:0] GMAX = '1;

  typedef enum logic [1:0] {
    K_DIGIT,
    K_BLANK,
    K_BAD
  } kind_t;

  logic [6:0]         r_sample;
  logic [6:0]         r_cand;
  logic [3:0]         r_cnt;
  logic               r_done;
  logic [6:0]         r_acc;
  logic               r_acc_valid;
  logic [3:0]         r_prev;
  logic               r_prev_valid;
  logic [COUNT_W-1:0] r_gap;
  logic [3:0]         r_digit;
  logic               r_dv;
  logic               r_blank;
  logic               r_inv;
  logic               r_seq;
  logic [COUNT_W-1:0] r_period;

  logic        w_match;
  logic        w_accept;
  kind_t       w_kind;
  logic [3:0]  w_dec;
  logic [3:0]  w_next;
  logic [3:0]  w_zero_eight;

  assign w_match = (r_sample == r_cand);

  // r_done stops a held candidate from firing again; invalid
  // patterns never become the accepted pattern, so this is needed.
  assign w_accept = (r_cnt == STAB) && !r_done &&
                    (!r_acc_valid || (r_cand != r_acc));

  assign w_next = (r_prev == 4'd9) ? 4'd0 : r_prev + 4'd1;

  // All-segments-lit is 0 only when wrapping from 9 or with no context.
  assign w_zero_eight = (!r_prev_valid || r_prev == 4'd9) ? 4'd0 : 4'd8;

  always_comb begin
    w_kind = K_DIGIT;
    w_dec  = 4'd0;
    unique case (1'b1)
      (r_cand == 7'b0110000): w_dec = 4'd1;
      (r_cand == 7'b1101101): w_dec = 4'd2;
      (r_cand == 7'b1111001): w_dec = 4'd3;
      (r_cand == 7'b0110011): w_dec = 4'd4;
      (r_cand == 7'b1011011): w_dec = 4'd5;
      (r_cand == 7'b0011111): w_dec = 4'd6;
      (r_cand == 7'b1110000): w_dec = 4'd7;
      (r_cand == 7'b1110011): w_dec = 4'd9;
      (r_cand == 7'b1111111): w_dec = w_zero_eight;
      (r_cand == 7'b0000000): w_kind = K_BLANK;
      default:                w_kind = K_BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sample     <= '0;
      r_cand       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_acc        <= '0;
      r_acc_valid  <= 1'b0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_gap        <= '0;
      r_digit      <= '0;
      r_dv         <= 1'b0;
      r_blank      <= 1'b0;
      r_inv        <= 1'b0;
      r_seq        <= 1'b0;
      r_period     <= '0;
    end else begin
      r_sample <= seg_in;
      r_dv     <= 1'b0;
      r_inv    <= 1'b0;
      r_seq    <= 1'b0;

      if (!w_match) begin
        r_cand <= r_sample;
        r_cnt  <= 4'd1;
        r_done <= 1'b0;
      end else begin
        if (r_cnt != STAB) r_cnt <= r_cnt + 4'd1;
        if (w_accept) r_done <= 1'b1;
      end

      if (r_gap != GMAX) r_gap <= r_gap + COUNT_W'(1);

      if (w_accept) begin
        unique case (w_kind)
          K_DIGIT: begin
            r_digit     <= w_dec;
            r_dv        <= 1'b1;
            r_blank     <= 1'b0;
            r_acc       <= r_cand;
            r_acc_valid <= 1'b1;
            if (r_prev_valid) begin
              r_seq    <= (w_dec != w_next);
              r_period <= (r_gap == GMAX) ? r_gap : r_gap + COUNT_W'(1);
            end
            r_prev       <= w_dec;
            r_prev_valid <= 1'b1;
            r_gap        <= '0;
          end
          K_BLANK: begin
            r_blank      <= 1'b1;
            r_acc        <= r_cand;
            r_acc_valid  <= 1'b1;
            r_prev_valid <= 1'b0;
            r_gap        <= '0;
          end
          default: begin
            r_inv <= 1'b1;
          end
        endcase
      end
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_dv;
  assign blank       = r_blank;
  assign invalid     = r_inv;
  assign seq_error   = r_seq;
  assign period      = r_period;
  assign stall       = r_prev_valid && (r_gap >= TO);

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder (STABLE_CYCLES=4, TIMEOUT=50).
// Ports: drives clk, reset, seg_in; observes all decoder outputs.
module tb_seven_segment_decoder;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        blank;
  logic        invalid;
  logic        seq_error;
  logic        stall;
  logic [24:0] period;

  int checks;
  int failures;
  int dv_cnt;
  int dv_at;
  int inv_cnt;
  int se_cnt;
  logic [3:0] dv_digit;
  logic       dv_seq;
  logic [6:0] P [10];

  seven_segment_decoder #(
    .STABLE_CYCLES(4),
    .COUNT_W(25),
    .TIMEOUT(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .digit(digit),
    .digit_valid(digit_valid),
    .blank(blank),
    .invalid(invalid),
    .seq_error(seq_error),
    .stall(stall),
    .period(period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear();
    dv_cnt   = 0;
    dv_at    = -1;
    inv_cnt  = 0;
    se_cnt   = 0;
    dv_digit = 4'hf;
    dv_seq   = 1'bx;
  endtask

  // Drives a pattern for n edges; i=1 is the first edge that sees it.
  task automatic run(input logic [6:0] pat, input int n);
    seg_in = pat;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (digit_valid) begin
        if (dv_cnt == 0) begin
          dv_at    = i;
          dv_digit = digit;
          dv_seq   = seq_error;
        end
        dv_cnt++;
      end
      if (invalid) inv_cnt++;
      if (seq_error) se_cnt++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    seg_in = 7'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({digit, digit_valid, blank, invalid, seq_error, stall, period} !== '0) begin
      failures++;
      $display("FAIL reset_outputs digit=%0d dv=%b blank=%b inv=%b seq=%b stall=%b period=%0d want all 0",
               digit, digit_valid, blank, invalid, seq_error, stall, period);
    end
    reset = 1'b1;
  endtask

  task automatic test_count_sweep();
    int tot_se;
    tot_se = 0;
    for (int d = 0; d <= 10; d++) begin
      logic [3:0] exp;
      exp = 4'(d % 10);
      clear();
      run(P[d % 10], 100);
      tot_se += se_cnt;
      checks++;
      if (dv_cnt != 1 || dv_at != 6 || dv_digit !== exp) begin
        failures++;
        $display("FAIL sweep_strobe d=%0d got cnt=%0d at=%0d digit=%0d want cnt=1 at=6 digit=%0d",
                 d, dv_cnt, dv_at, dv_digit, exp);
      end
      if (d >= 1) begin
        checks++;
        if (period !== 25'd100) begin
          failures++;
          $display("FAIL sweep_period d=%0d got %0d want 100", d, period);
        end
      end
    end
    checks++;
    if (tot_se != 0) begin
      failures++;
      $display("FAIL sweep_seq_error got %0d pulses want 0", tot_se);
    end
  endtask

  task automatic test_glitch();
    run(P[2], 20);
    clear();
    run(P[1], 3);
    run(P[2], 20);
    checks++;
    if (dv_cnt != 0 || inv_cnt != 0) begin
      failures++;
      $display("FAIL glitch_short got dv=%0d inv=%0d want 0 0", dv_cnt, inv_cnt);
    end
    clear();
    run(P[1], 4);
    run(P[2], 20);
    checks++;
    if (dv_cnt != 2 || dv_digit !== 4'd1 || dv_seq !== 1'b1) begin
      failures++;
      $display("FAIL glitch_accept got cnt=%0d digit=%0d seq=%b want cnt=2 digit=1 seq=1",
               dv_cnt, dv_digit, dv_seq);
    end
    checks++;
    if (se_cnt != 1 || digit !== 4'd2) begin
      failures++;
      $display("FAIL glitch_return got se=%0d digit=%0d want se=1 digit=2", se_cnt, digit);
    end
  endtask

  task automatic test_zero_eight();
    logic [6:0] pre  [4];
    logic [3:0] expd [4];
    logic       exps [4];
    pre[0] = P[7];       expd[0] = 4'd8; exps[0] = 1'b0;
    pre[1] = P[9];       expd[1] = 4'd0; exps[1] = 1'b0;
    pre[2] = P[3];       expd[2] = 4'd8; exps[2] = 1'b1;
    pre[3] = 7'b0000000; expd[3] = 4'd0; exps[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clear();
      run(pre[k], 20);
      if (k == 3) begin
        checks++;
        if (blank !== 1'b1 || dv_cnt != 0 || digit !== 4'd8) begin
          failures++;
          $display("FAIL blank_accept got blank=%b dv=%0d digit=%0d want 1 0 8",
                   blank, dv_cnt, digit);
        end
      end
      clear();
      run(P[8], 20);
      checks++;
      if (dv_cnt != 1 || dv_digit !== expd[k] || dv_seq !== exps[k] || blank !== 1'b0) begin
        failures++;
        $display("FAIL zero_eight case=%0d got cnt=%0d digit=%0d seq=%b blank=%b want 1 %0d %b 0",
                 k, dv_cnt, dv_digit, dv_seq, blank, expd[k], exps[k]);
      end
    end
  endtask

  task automatic test_invalid();
    run(P[5], 20);
    clear();
    run(7'b1000000, 10);
    checks++;
    if (inv_cnt != 1 || dv_cnt != 0 || digit !== 4'd5) begin
      failures++;
      $display("FAIL invalid_pulse got inv=%0d dv=%0d digit=%0d want 1 0 5",
               inv_cnt, dv_cnt, digit);
    end
    clear();
    run(P[5], 20);
    checks++;
    if (inv_cnt != 0 || dv_cnt != 0) begin
      failures++;
      $display("FAIL invalid_return got inv=%0d dv=%0d want 0 0", inv_cnt, dv_cnt);
    end
  endtask

  task automatic test_stall();
    bit found;
    int k;
    found  = 0;
    seg_in = P[3];
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (digit_valid) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found || stall !== 1'b0 || digit !== 4'd3) begin
      failures++;
      $display("FAIL stall_accept3 got found=%0d stall=%b digit=%0d want 1 0 3",
               found, stall, digit);
    end
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (stall) begin
        k = i;
        break;
      end
    end
    checks++;
    if (k != 50) begin
      failures++;
      $display("FAIL stall_rise got %0d edges want 50", k);
    end
    found  = 0;
    seg_in = P[4];
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (digit_valid) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found || stall !== 1'b0 || seq_error !== 1'b0 || digit !== 4'd4) begin
      failures++;
      $display("FAIL stall_clear got found=%0d stall=%b seq=%b digit=%0d want 1 0 0 4",
               found, stall, seq_error, digit);
    end
  endtask

  task automatic test_mid_reset();
    run(P[4], 10);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({digit, digit_valid, blank, invalid, seq_error, stall, period} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs digit=%0d dv=%b blank=%b inv=%b seq=%b stall=%b period=%0d want all 0",
               digit, digit_valid, blank, invalid, seq_error, stall, period);
    end
    reset = 1'b1;
    clear();
    run(P[4], 20);
    checks++;
    if (dv_cnt != 1 || dv_at != 6 || dv_digit !== 4'd4 || dv_seq !== 1'b0 || period !== '0) begin
      failures++;
      $display("FAIL midreset_first got cnt=%0d at=%0d digit=%0d seq=%b period=%0d want 1 6 4 0 0",
               dv_cnt, dv_at, dv_digit, dv_seq, period);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    P[0] = 7'b1111111;
    P[1] = 7'b0110000;
    P[2] = 7'b1101101;
    P[3] = 7'b1111001;
    P[4] = 7'b0110011;
    P[5] = 7'b1011011;
    P[6] = 7'b0011111;
    P[7] = 7'b1110000;
    P[8] = 7'b1111111;
    P[9] = 7'b1110011;
    clear();
    test_reset();
    test_count_sweep();
    test_glitch();
    test_zero_eight();
    test_invalid();
    test_stall();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
